// File: rtl/nist_pkg.sv
// Shared defaults and helpers for the NIST SP800-22 on-line health tests.
package nist_pkg;

  localparam int unsigned BLK_LOG2_DEF = 7;
  localparam int unsigned LIMIT_DEF    = 29;
  localparam int unsigned WIN_LOG2_DEF = 7;
  localparam int unsigned MAX_FAIL_DEF = 5;

  // Step applied to the running sum for a 1 bit and for a 0 bit
  localparam int STEP_ONE  = 1;
  localparam int STEP_ZERO = -1;

  // Sum width: two extra bits so +/-2^blk_log2 fits in two's complement
  function automatic int unsigned sn_width(input int unsigned blk_log2);
    return blk_log2 + 2;
  endfunction

endpackage

// File: rtl/nist_sn_accum.sv
// Running-sum accumulator for one monobit block: Sn register, bit counter,
// |Sn| threshold compare and registered block-done/verdict outputs.
module nist_sn_accum
  import nist_pkg::*;
#(
  parameter int unsigned BLK_LOG2 = BLK_LOG2_DEF,
  parameter int unsigned LIMIT    = LIMIT_DEF
) (
`ifdef NIST_FREQ_STATS_EN
  output logic [BLK_LOG2:0] abs_sn_c,
`endif
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              in_valid,
  input  logic              rnd,
  output logic              blk_done,
  output logic              blk_fail,
  output logic              blk_end_c,
  output logic              blk_fail_c
);

  localparam int unsigned SN_W  = sn_width(BLK_LOG2);
  localparam int unsigned ABS_W = SN_W - 1;
  localparam int unsigned CNT_W = BLK_LOG2;

  logic [SN_W-1:0]  sn;
  logic [SN_W-1:0]  sn_next;
  logic [SN_W-1:0]  step;
  logic [ABS_W-1:0] abs_c;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept;

  // Magnitude uses only the low bits: the sum never exceeds 2^BLK_LOG2 in size
  always_comb begin
    accept     = in_valid & ~clr;
    step       = rnd ? SN_W'(STEP_ONE) : SN_W'(STEP_ZERO);
    sn_next    = sn + step;
    abs_c      = sn_next[SN_W-1] ? ABS_W'(~sn_next[ABS_W-1:0] + ABS_W'(1))
                                 : sn_next[ABS_W-1:0];
    blk_end_c  = accept & (&bit_cnt);
    blk_fail_c = (abs_c >= ABS_W'(LIMIT));
  end

`ifdef NIST_FREQ_STATS_EN
  assign abs_sn_c = abs_c;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sn       <= '0;
      bit_cnt  <= '0;
      blk_done <= 1'b0;
      blk_fail <= 1'b0;
    end else if (clr) begin
      sn       <= '0;
      bit_cnt  <= '0;
      blk_done <= 1'b0;
      blk_fail <= 1'b0;
    end else begin
      blk_done <= blk_end_c;
      if (accept) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        sn      <= blk_end_c ? '0 : sn_next;
      end
      if (blk_end_c) begin
        blk_fail <= blk_fail_c;
      end
    end
  end

endmodule

// File: rtl/nist_freq_test.sv
// NIST SP800-22 Frequency (Monobit) health monitor: per-block verdicts,
// per-window fail counting and sticky error. Optional NIST_FREQ_STATS_EN adds stats outputs.
module nist_freq_test
  import nist_pkg::*;
#(
  parameter int unsigned BLK_LOG2 = BLK_LOG2_DEF,
  parameter int unsigned LIMIT    = LIMIT_DEF,
  parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF,
  parameter int unsigned MAX_FAIL = MAX_FAIL_DEF
) (
`ifdef NIST_FREQ_STATS_EN
  output logic [BLK_LOG2:0]   last_abs_sn,
  output logic [15:0]         win_cnt,
`endif
  input  logic                clk,
  input  logic                rstn,
  input  logic                clr,
  input  logic                in_valid,
  input  logic                RND_in,
  output logic                blk_done,
  output logic                blk_fail,
  output logic                win_done,
  output logic [WIN_LOG2:0]   fail_cnt,
  output logic                error1
);

  localparam int unsigned FCNT_W = WIN_LOG2 + 1;

  logic                blk_end_c;
  logic                blk_fail_c;
  logic                win_end_c;
  logic [WIN_LOG2-1:0] blk_cnt;
  logic [FCNT_W-1:0]   fail_cnt_next_c;

`ifdef NIST_FREQ_STATS_EN
  logic [BLK_LOG2:0]   abs_sn_c;
`endif

  nist_sn_accum #(
    .BLK_LOG2 (BLK_LOG2),
    .LIMIT    (LIMIT)
  ) u_accum (
`ifdef NIST_FREQ_STATS_EN
    .abs_sn_c   (abs_sn_c),
`endif
    .clk        (clk),
    .rstn       (rstn),
    .clr        (clr),
    .in_valid   (in_valid),
    .rnd        (RND_in),
    .blk_done   (blk_done),
    .blk_fail   (blk_fail),
    .blk_end_c  (blk_end_c),
    .blk_fail_c (blk_fail_c)
  );

  // Fail count including the block finishing this cycle
  always_comb begin
    fail_cnt_next_c = fail_cnt + FCNT_W'(blk_fail_c);
    win_end_c       = blk_end_c & (&blk_cnt);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blk_cnt  <= '0;
      fail_cnt <= '0;
      win_done <= 1'b0;
      error1   <= 1'b0;
    end else if (clr) begin
      blk_cnt  <= '0;
      fail_cnt <= '0;
      win_done <= 1'b0;
      error1   <= 1'b0;
    end else begin
      win_done <= win_end_c;
      if (blk_end_c) begin
        blk_cnt <= blk_cnt + WIN_LOG2'(1);
        if (win_end_c) begin
          fail_cnt <= '0;
          if (fail_cnt_next_c > FCNT_W'(MAX_FAIL)) begin
            error1 <= 1'b1;
          end
        end else begin
          fail_cnt <= fail_cnt_next_c;
        end
      end
    end
  end

`ifdef NIST_FREQ_STATS_EN
  // Window counter saturates rather than wrapping
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_abs_sn <= '0;
      win_cnt     <= '0;
    end else if (clr) begin
      last_abs_sn <= '0;
      win_cnt     <= '0;
    end else begin
      if (blk_end_c) begin
        last_abs_sn <= abs_sn_c;
      end
      if (win_end_c && (win_cnt != 16'hFFFF)) begin
        win_cnt <= win_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nist_freq_test.sv
// Directed self-checking bench for nist_freq_test at default parameters.
module tb_nist_freq_test;

  logic       clk = 1'b0;
  logic       rstn, clr, in_valid, RND_in;
  logic       blk_done, blk_fail, win_done, error1;
  logic [7:0] fail_cnt;
`ifdef NIST_FREQ_STATS_EN
  logic [7:0]  last_abs_sn;
  logic [15:0] win_cnt;
`endif

  nist_freq_test dut (
`ifdef NIST_FREQ_STATS_EN
    .last_abs_sn (last_abs_sn),
    .win_cnt     (win_cnt),
`endif
    .clk      (clk),
    .rstn     (rstn),
    .clr      (clr),
    .in_valid (in_valid),
    .RND_in   (RND_in),
    .blk_done (blk_done),
    .blk_fail (blk_fail),
    .win_done (win_done),
    .fail_cnt (fail_cnt),
    .error1   (error1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] bits;
    bit           do_clr;
    logic         exp_fail;
    logic [7:0]   exp_cnt;
    string        name;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   early   = 1'b0;
  int   m_cnt   = 0;
  bit   m_err   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] pat(input int ones, input bit alt);
    logic [127:0] b;
    for (int i = 0; i < 128; i++) b[i] = alt ? (i % 2 == 0) : (i < ones);
    return b;
  endfunction

  task automatic add_vec(input logic [127:0] bits, input bit do_clr, input logic exp_fail,
                         input logic [7:0] exp_cnt, input string name);
    vec_t v;
    v.bits = bits; v.do_clr = do_clr; v.exp_fail = exp_fail;
    v.exp_cnt = exp_cnt; v.name = name;
    vq.push_back(v);
  endtask

  task automatic drive_bits(input logic [127:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (blk_done === 1'b1 || win_done === 1'b1) early = 1'b1;
      in_valid = 1'b1;
      RND_in   = bits[i];
    end
  endtask

  // Drive one full block, then idle one cycle; outputs are sampled on return
  task automatic run_block(input logic [127:0] bits);
    early = 1'b0;
    drive_bits(bits, 128);
    @(negedge clk);
    in_valid = 1'b0;
    RND_in   = 1'b0;
    chk("no_early_done", 32'(early), 32'd0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    m_cnt = 0; m_err = 1'b0;
    chk("clr_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("clr_error1", 32'(error1), 32'd0);
    chk("clr_blk_fail", 32'(blk_fail), 32'd0);
  endtask

  // Run nblk blocks of a window; fmask[j] selects an all-ones (failing) block
  task automatic run_window(input logic [127:0] fmask, input int nblk, input string tag);
    for (int j = 0; j < nblk; j++) begin
      run_block(fmask[j] ? pat(128, 1'b0) : pat(0, 1'b1));
      if (fmask[j]) m_cnt++;
      chk({tag, "_blk_done"}, 32'(blk_done), 32'd1);
      chk({tag, "_blk_fail"}, 32'(blk_fail), 32'(fmask[j]));
      if (j == 127) begin
        if (m_cnt > 5) m_err = 1'b1;
        m_cnt = 0;
        chk({tag, "_win_done"}, 32'(win_done), 32'd1);
      end else begin
        chk({tag, "_win_idle"}, 32'(win_done), 32'd0);
      end
      chk({tag, "_fail_cnt"}, 32'(fail_cnt), 32'(m_cnt));
      chk({tag, "_error1"}, 32'(error1), 32'(m_err));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] mask;
    rstn = 1'b1; clr = 1'b0; in_valid = 1'b0; RND_in = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("rst_blk_done", 32'(blk_done), 32'd0);
    chk("rst_blk_fail", 32'(blk_fail), 32'd0);
    chk("rst_win_done", 32'(win_done), 32'd0);
    chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("rst_error1", 32'(error1), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Single-block verdicts around the |Sn| >= 29 threshold
    add_vec(pat(128, 1'b0), 1'b0, 1'b1, 8'd1, "all_ones_sn128");
    add_vec(pat(0, 1'b1),   1'b1, 1'b0, 8'd0, "alternating_sn0");
    add_vec(pat(78, 1'b0),  1'b0, 1'b0, 8'd0, "sn_plus28");
    add_vec(pat(79, 1'b0),  1'b0, 1'b1, 8'd1, "sn_plus30");
    add_vec(pat(49, 1'b0),  1'b0, 1'b1, 8'd2, "sn_minus30");
    add_vec(pat(0, 1'b0),   1'b0, 1'b1, 8'd3, "all_zeros_sn_m128");
    add_vec(pat(50, 1'b0),  1'b0, 1'b0, 8'd3, "sn_minus28");
    foreach (vq[k]) begin
      if (vq[k].do_clr) pulse_clr();
      run_block(vq[k].bits);
      chk({vq[k].name, "_blk_done"}, 32'(blk_done), 32'd1);
      chk({vq[k].name, "_blk_fail"}, 32'(blk_fail), 32'(vq[k].exp_fail));
      chk({vq[k].name, "_fail_cnt"}, 32'(fail_cnt), 32'(vq[k].exp_cnt));
      chk({vq[k].name, "_win_done"}, 32'(win_done), 32'd0);
      @(negedge clk);
      chk({vq[k].name, "_done_pulse"}, 32'(blk_done), 32'd0);
      chk({vq[k].name, "_fail_held"}, 32'(blk_fail), 32'(vq[k].exp_fail));
    end

    // Stalled input: bits accepted only every other cycle
    pulse_clr();
    early = 1'b0;
    for (int c = 0; c < 255; c++) begin
      @(negedge clk);
      if (blk_done === 1'b1) early = 1'b1;
      in_valid = (c % 2 == 0);
      RND_in   = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("stall_no_early", 32'(early), 32'd0);
    chk("stall_blk_done", 32'(blk_done), 32'd1);
    chk("stall_blk_fail", 32'(blk_fail), 32'd1);
    chk("stall_fail_cnt", 32'(fail_cnt), 32'd1);

    // Async reset mid-block discards the partial block
    early = 1'b0;
    drive_bits(pat(128, 1'b0), 60);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("midrst_blk_fail", 32'(blk_fail), 32'd0);
    chk("midrst_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("midrst_blk_done", 32'(blk_done), 32'd0);
    chk("midrst_error1", 32'(error1), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    run_block(pat(0, 1'b1));
    chk("postrst_blk_done", 32'(blk_done), 32'd1);
    chk("postrst_blk_fail", 32'(blk_fail), 32'd0);
    chk("postrst_fail_cnt", 32'(fail_cnt), 32'd0);

    // Window with 5 failures, then 6, then clean
    pulse_clr();
    mask = '0; mask[0] = 1'b1; mask[10] = 1'b1; mask[50] = 1'b1;
    mask[100] = 1'b1; mask[127] = 1'b1;
    run_window(mask, 128, "winA");
    mask = '0; mask[1] = 1'b1; mask[2] = 1'b1; mask[3] = 1'b1;
    mask[64] = 1'b1; mask[126] = 1'b1; mask[127] = 1'b1;
    run_window(mask, 128, "winB");
    run_window('0, 128, "winC");

    // clr on the last bit of a window-ending block overrides completion
    mask = '0; mask[5] = 1'b1; mask[6] = 1'b1;
    run_window(mask, 127, "winD");
    drive_bits(pat(128, 1'b0), 127);
    @(negedge clk);
    in_valid = 1'b1; RND_in = 1'b1; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    chk("clrwin_blk_done", 32'(blk_done), 32'd0);
    chk("clrwin_win_done", 32'(win_done), 32'd0);
    chk("clrwin_error1", 32'(error1), 32'd0);
    chk("clrwin_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("clrwin_blk_fail", 32'(blk_fail), 32'd0);
    run_block(pat(128, 1'b0));
    chk("afterclr_blk_done", 32'(blk_done), 32'd1);
    chk("afterclr_win_done", 32'(win_done), 32'd0);
    chk("afterclr_fail_cnt", 32'(fail_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
